prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader upstream of the CPU; replaces the simulation-only image preload for hardware bring-up.
- Consumes a framed byte stream from the UART receiver and assembles 16-bit instruction words.
- Writes the words into the instruction memory write port and verifies a checksum.
- Holds the CPU in reset until a load succeeds, then releases it.

Parameters:
ADDR_W, 15, instruction memory word-address width (32768 words)
MAX_WORDS, 32768, largest accepted word count; must be <= 2^ADDR_W
TIMEOUT, 1000000, idle clock cycles allowed between bytes inside a frame

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
rx_data  input  8  received byte
rx_valid  input  1  rx_data valid this cycle
rx_ready  output  1  loader accepts byte; transfer = rx_valid & rx_ready
restart  input  1  single-cycle pulse; re-arm loader from RUN or ERROR
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_W  instruction memory word address
imem_wdata  output  16  instruction word
cpu_reset  output  1  active-high reset to the CPU core
load_done  output  1  high while in RUN
load_error  output  1  high while in ERROR
err_code  output  2  0 none, 1 bad count, 2 checksum mismatch, 3 timeout

Behaviour:
- Frame format: sync 0xA5; count_hi; count_lo; count words, each sent high byte then low byte; checksum byte.
- Checksum byte = 8-bit modulo-256 sum of all payload data bytes only (sync and count excluded).
- Reset values: rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, load_error=0, err_code=0, state=SYNC. All internal counters are cleared.
- States and transitions:
  - SYNC: a byte of 0xA5 goes to CNT_HI. Any other byte is consumed and discarded. No timeout applies in SYNC.
  - CNT_HI: the byte is latched into count[15:8]; go to CNT_LO.
  - CNT_LO: the byte is latched into count[7:0]. If count==0 or count>MAX_WORDS, go to ERROR with err_code=1. Otherwise clear word_idx, sum and addr, and go to DATA_HI.
  - DATA_HI: the byte is latched as the high byte and added to sum; go to DATA_LO.
  - DATA_LO: the byte is added to sum. On the next cycle imem_we=1, imem_wdata={hi,byte}, imem_addr=word_idx. word_idx then increments. If the word just written was word count-1, go to CHK; otherwise go to DATA_HI.
  - CHK: if byte==sum[7:0], go to RUN; otherwise go to ERROR with err_code=2.
  - RUN: rx_ready=0, cpu_reset=0, load_done=1. restart returns to SYNC with cpu_reset=1 and load_done=0 on the following cycle.
  - ERROR: rx_ready=0, cpu_reset=1, load_error=1, err_code is held. restart returns to SYNC and clears err_code and load_error.
- rx_ready is 1 in SYNC, CNT_HI, CNT_LO, DATA_HI, DATA_LO and CHK; it is 0 in RUN and ERROR. rx_ready is combinational from state only.
- Write timing: the imem_we pulse occurs exactly one cycle after the low byte is accepted. It is never asserted outside that cycle. Back-to-back bytes on consecutive cycles must not lose a write.
- Timeout: an idle counter runs in CNT_HI through CHK. It is cleared on every accepted byte and on each state entry. When it reaches TIMEOUT-1 with no transfer, go to ERROR with err_code=3. A transfer in that same cycle wins and the counter clears.
- restart is ignored in SYNC through CHK. While rx_valid is held, restart takes effect and the byte is not consumed, because rx_ready=0.
- cpu_reset is driven from a register, so it is glitch-free. It deasserts on the first cycle in RUN.
- Asynchronous reset mid-load aborts immediately: state returns to SYNC and the CPU stays in reset. Words already written remain in memory and are undefined for the next load.
- Widths: sum is 8-bit and wraps. word_idx is 16-bit and compared against count. imem_addr is the low ADDR_W bits of word_idx.

Test Plan:
- Reset, then stream A5 00 02 12 34 FF FF 44 -> imem writes (addr 0, 0x1234) and (addr 1, 0xFFFF) on single-cycle strobes; then load_done=1, cpu_reset=0, rx_ready=0, err_code=0.
- Bytes 00 7E A5 00 01 AB CD 78 -> leading 00 and 7E are discarded; one write (0, 0xABCD); RUN.
- A5 00 00 -> ERROR with err_code=1, no imem_we. Separately, A5 80 01 with MAX_WORDS=32768 -> err_code=1.
- A5 00 01 11 22 00 -> write (0, 0x1122) occurs, then ERROR with err_code=2 and cpu_reset stays 1. A restart pulse returns to SYNC with err_code=0; a valid frame then reaches RUN.
- A5 00 01 11, then rx_valid low for TIMEOUT cycles (TIMEOUT=16 in bench) -> ERROR with err_code=3 on cycle 16. A byte arriving on cycle 15 prevents the error.
- Assert reset (0) during DATA_LO with rx_valid held -> all outputs at reset values asynchronously. After release, a full frame loads to RUN.

Source files
------------

// File: rtl/prog_loader.sv
// Boot loader: parses a framed UART byte stream, writes 16-bit words to instruction
// memory, verifies the checksum and holds the CPU in reset until a load succeeds.
module prog_loader #(
  parameter int ADDR_W    = 15,
  parameter int MAX_WORDS = 32768,
  parameter int TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [1:0]        err_code
);

  localparam int             IW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0]  IDLE_MAX = IW'(TIMEOUT - 1);
  localparam logic [16:0]    MAX_CNT  = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    SYNC, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHK, RUN, ERROR
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    err_nx;
  logic [15:0]   count, word_idx, cnt_new;
  logic [7:0]    hi_byte, sum;
  logic [IW-1:0] idle;
  logic          xfer, timed, tmo, bad_cnt;

  assign rx_ready   = (state != RUN) && (state != ERROR);
  assign load_done  = (state == RUN);
  assign load_error = (state == ERROR);
  assign xfer       = rx_valid & rx_ready;
  assign timed      = (state != SYNC) && rx_ready;
  assign tmo        = timed && !xfer && (idle == IDLE_MAX);
  assign cnt_new    = {count[15:8], rx_data};
  assign bad_cnt    = (cnt_new == 16'd0) || ({1'b0, cnt_new} > MAX_CNT);

  always_comb begin
    state_nx = state;
    err_nx   = err_code;
    case (state)
      SYNC:    if (xfer && rx_data == 8'hA5) state_nx = CNT_HI;
      CNT_HI:  if (xfer) state_nx = CNT_LO;
      CNT_LO:  if (xfer) begin
                 if (bad_cnt) begin
                   state_nx = ERROR;
                   err_nx   = 2'd1;
                 end else begin
                   state_nx = DATA_HI;
                 end
               end
      DATA_HI: if (xfer) state_nx = DATA_LO;
      DATA_LO: if (xfer) state_nx = (word_idx == count - 16'd1) ? CHK : DATA_HI;
      CHK:     if (xfer) begin
                 if (rx_data == sum) begin
                   state_nx = RUN;
                 end else begin
                   state_nx = ERROR;
                   err_nx   = 2'd2;
                 end
               end
      RUN:     if (restart) state_nx = SYNC;
      ERROR:   if (restart) begin
                 state_nx = SYNC;
                 err_nx   = 2'd0;
               end
      default: state_nx = SYNC;
    endcase
    // a transfer in the expiring cycle keeps tmo low, so the byte wins
    if (tmo) begin
      state_nx = ERROR;
      err_nx   = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SYNC;
      err_code   <= 2'd0;
      cpu_reset  <= 1'b1;
      idle       <= '0;
      count      <= 16'd0;
      word_idx   <= 16'd0;
      hi_byte    <= 8'd0;
      sum        <= 8'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 16'd0;
    end else begin
      state     <= state_nx;
      err_code  <= err_nx;
      cpu_reset <= (state_nx != RUN);
      imem_we   <= 1'b0;

      if (xfer || state_nx != state || !timed) idle <= '0;
      else                                      idle <= idle + 1'b1;

      if (xfer) begin
        case (state)
          CNT_HI: count[15:8] <= rx_data;
          CNT_LO: begin
            count[7:0] <= rx_data;
            word_idx   <= 16'd0;
            sum        <= 8'd0;
          end
          DATA_HI: begin
            hi_byte <= rx_data;
            sum     <= sum + rx_data;
          end
          DATA_LO: begin
            sum        <= sum + rx_data;
            imem_we    <= 1'b1;
            imem_wdata <= {hi_byte, rx_data};
            imem_addr  <= word_idx[ADDR_W-1:0];
            word_idx   <= word_idx + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboarded bench for prog_loader: frame-level reference model, directed corner
// cases and randomized frames with random gaps and garbage prefixes.
module tb_prog_loader;
  localparam int ADDR_W    = 15;
  localparam int MAX_WORDS = 32768;
  localparam int TIMEOUT   = 16;
  localparam int ST_RUN    = 1;
  localparam int ST_ERR    = 2;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  logic              clk, reset, rx_valid, rx_ready, restart;
  logic [7:0]        rx_data;
  logic              imem_we, cpu_reset, load_done, load_error;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic [1:0]        err_code;

  int  vectors = 0, miscompares = 0;
  wr_t exp_q[$];
  logic prev_we = 1'b0;

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .restart(restart), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .load_done(load_done), .load_error(load_error), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every write strobe must match the next expected write
  always @(negedge clk) begin
    if (reset && imem_we) begin
      chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk("wr_data", 32'(imem_wdata), 32'(e.data));
      end
    end
    prev_we = reset && imem_we;
  end

  // frame-level reference: queue expected writes, return final outcome
  task automatic model(input bq_t f, output int st, output int err);
    int i = 0;
    int cnt;
    logic [7:0] s = 8'd0;
    wr_t w;
    while (i < f.size() && f[i] != 8'hA5) i++;
    i++;
    cnt = {f[i], f[i+1]};
    i += 2;
    if (cnt == 0 || cnt > MAX_WORDS) begin
      st = ST_ERR; err = 1;
      return;
    end
    for (int k = 0; k < cnt; k++) begin
      w.addr = ADDR_W'(k);
      w.data = {f[i], f[i+1]};
      exp_q.push_back(w);
      s = s + f[i] + f[i+1];
      i += 2;
    end
    if (f[i] == s) begin st = ST_RUN; err = 0; end
    else           begin st = ST_ERR; err = 2; end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 8) begin @(posedge clk); #1; n++; end
    if (!rx_ready) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input int st, input int err);
    @(negedge clk);
    chk({tag, "_load_done"},  32'(load_done),  32'(st == ST_RUN));
    chk({tag, "_load_error"}, 32'(load_error), 32'(st == ST_ERR));
    chk({tag, "_err_code"},   32'(err_code),   32'(err));
    chk({tag, "_cpu_reset"},  32'(cpu_reset),  32'(st != ST_RUN));
    chk({tag, "_rx_ready"},   32'(rx_ready),   32'(st == 0));
    chk({tag, "_wr_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_restart(input string tag);
    @(posedge clk); #1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    check_status({tag, "_restart"}, 0, 0);
  endtask

  task automatic run_frame(input string tag, input bq_t f, input int max_gap);
    int st, err;
    model(f, st, err);
    foreach (f[i]) begin
      send_byte(f[i]);
      idle_cycles($urandom_range(0, max_gap));
    end
    idle_cycles(2);
    check_status(tag, st, err);
    do_restart(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f;
    int  st, err;
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; restart = 1'b0;
    idle_cycles(3);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", 32'(imem_wdata), 32'd0);
    check_status("rst", 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle_cycles(2);

    run_frame("two_words", '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hFF, 8'hFF, 8'h44}, 0);
    run_frame("garbage",   '{8'h00, 8'h7E, 8'hA5, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'h78}, 0);
    run_frame("cnt_zero",  '{8'hA5, 8'h00, 8'h00}, 1);
    run_frame("cnt_over",  '{8'hA5, 8'h80, 8'h01}, 1);

    // checksum error, then restart with a byte already waiting
    f = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h00};
    model(f, st, err);
    foreach (f[i]) send_byte(f[i]);
    idle_cycles(2);
    check_status("bad_sum", st, err);
    rx_data = 8'hA5; rx_valid = 1'b1; restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    @(negedge clk);
    chk("held_restart_err", 32'(err_code), 32'd0);
    chk("held_restart_ready", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    f = '{8'hA5, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'h78};
    model(f, st, err);
    for (int i = 1; i < f.size(); i++) send_byte(f[i]);
    idle_cycles(2);
    check_status("after_restart", st, err);
    do_restart("after_restart");

    // timeout fires on the 16th idle cycle, not before
    foreach (f[i]) if (i < 4) send_byte(f[i]);
    idle_cycles(TIMEOUT - 1);
    @(negedge clk);
    chk("tmo_early", 32'(load_error), 32'd0);
    idle_cycles(1);
    check_status("tmo", ST_ERR, 3);
    do_restart("tmo");

    // a byte on the 15th idle cycle keeps the load alive
    f = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
    model(f, st, err);
    foreach (f[i]) if (i < 4) send_byte(f[i]);
    idle_cycles(TIMEOUT - 2);
    send_byte(f[4]);
    send_byte(f[5]);
    idle_cycles(2);
    check_status("tmo_saved", st, err);
    do_restart("tmo_saved");

    // count of exactly MAX_WORDS is legal: ends in timeout, not bad count
    send_byte(8'hA5); send_byte(8'h80); send_byte(8'h00);
    idle_cycles(TIMEOUT);
    check_status("cnt_max", ST_ERR, 3);
    do_restart("cnt_max");

    // async reset while a low byte is presented in DATA_LO
    begin
      wr_t w;
      w.addr = '0; w.data = 16'h1234;
      exp_q.push_back(w);
    end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    rx_data = 8'h78; rx_valid = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("arst_imem_we", 32'(imem_we), 32'd0);
    chk("arst_imem_addr", 32'(imem_addr), 32'd0);
    chk("arst_imem_wdata", 32'(imem_wdata), 32'd0);
    chk("arst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("arst_rx_ready", 32'(rx_ready), 32'd1);
    chk("arst_done", 32'(load_done), 32'd0);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    run_frame("post_arst", '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'hAD}, 0);

    // randomized frames
    for (int n = 0; n < 25; n++) begin
      int ng, cnt;
      logic [7:0] b, s;
      f = {};
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        f.push_back(b);
      end
      f.push_back(8'hA5);
      if ($urandom_range(0, 9) == 0) begin
        f.push_back(8'h00); f.push_back(8'h00);
      end else begin
        cnt = $urandom_range(1, 8);
        f.push_back(8'h00); f.push_back(8'(cnt));
        s = 8'd0;
        for (int k = 0; k < 2 * cnt; k++) begin
          b = 8'($urandom_range(0, 255));
          f.push_back(b);
          s = s + b;
        end
        if ($urandom_range(0, 3) == 0) s = s ^ 8'(1 + $urandom_range(0, 254));
        f.push_back(s);
      end
      run_frame("rand", f, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
